// File: rtl/moncap_pkg.sv
// Shared definitions for the AND/OR monitor capture block: event word layout,
// monitor pair type and drop counter width.
package moncap_pkg;

  localparam int TS_W_DEF = 16;

  // Event word layout: {ts, m2, m1}
  localparam int M1_BIT = 0;
  localparam int M2_BIT = 1;
  localparam int TS_LSB = 2;

  localparam int DROP_CNT_W = 8;

  typedef struct packed {
    logic m2;
    logic m1;
  } mon_t;

  function automatic int ev_width(input int ts_w);
    return ts_w + 2;
  endfunction

endpackage

// File: rtl/moncap_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word,
// soft clear, and lossless simultaneous push/pop when full.
module moncap_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] dout_q, head_d;
  logic             push_ok, pop_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == CNT_W'(DEPTH));
  assign pop_ok     = pop && !empty && !clr;
  assign push_ok    = push && (!full || pop_ok) && !clr;
  assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

  // The head word is kept in its own register so the output is defined
  // after reset and holds its last value while empty.
  // NOTE: every signal driven in always_comb gets a default first, otherwise
  // an unassigned path infers a latch.
  always_comb begin
    head_d = dout_q;
    if (pop_ok) begin
      if (count_q == CNT_W'(1)) begin
        if (push_ok) head_d = din;
      end else begin
        head_d = mem[rd_ptr_nxt];
      end
    end else if (push_ok && empty) begin
      head_d = din;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_nxt;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
      dout_q <= head_d;
    end
  end

  // NOTE: storage is deliberately not reset; validity is tracked by count_q,
  // and leaving the array reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr_q] <= din;
  end

  assign dout  = dout_q;
  assign count = count_q;

endmodule

// File: rtl/andor_monitor_capture.sv
// Change-log capture of the AND/OR gate stage monitor pair into a time-stamped
// event FIFO. Optional dropped-event counter: define MONCAP_DROP_CNT_EN.
module andor_monitor_capture
  import moncap_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TS_W  = TS_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    monitor_m1,
  input  logic                    monitor_m2,
  input  logic                    en,
  input  logic                    clr,
  output logic                    ev_valid,
  input  logic                    ev_ready,
  output logic [TS_W+1:0]         ev_data,
  output logic [$clog2(DEPTH):0]  ev_count,
  output logic                    overflow
`ifdef MONCAP_DROP_CNT_EN
  ,
  output logic [DROP_CNT_W-1:0]   drop_cnt
`endif
);

  localparam int EV_W = ev_width(TS_W);

  mon_t            cur, prev_q;
  logic [TS_W-1:0] ts_q;
  logic [EV_W-1:0] ev_word;
  logic            push_req, pop_fire, drop;
  logic            fifo_full, fifo_empty;

  assign cur      = {monitor_m2, monitor_m1};
  assign push_req = en && (cur != prev_q);
  assign pop_fire = ev_ready && !fifo_empty;
  assign drop     = push_req && fifo_full && !pop_fire;

  always_comb begin
    ev_word                 = '0;
    ev_word[M1_BIT]         = cur.m1;
    ev_word[M2_BIT]         = cur.m2;
    ev_word[EV_W-1:TS_LSB]  = ts_q;
  end

  // prev follows the inputs even while capture is disabled or clearing, so
  // re-enabling never reports a stale difference.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
      ts_q   <= '0;
    end else begin
      prev_q <= cur;
      if (clr)     ts_q <= '0;
      else if (en) ts_q <= ts_q + TS_W'(1);
    end
  end

  moncap_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EV_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push_req),
    .pop   (ev_ready),
    .din   (ev_word),
    .dout  (ev_data),
    .count (ev_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign ev_valid = !fifo_empty;

`ifdef MONCAP_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_q <= drop_cnt_q + DROP_CNT_W'(1);
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != '0);
`else
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (rst || clr) overflow_q <= 1'b0;
    else if (drop)  overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_andor_monitor_capture.sv
// Directed bench for andor_monitor_capture: a 16-bit timestamp instance for
// the main flow and a 4-bit timestamp instance for wrap-around.
module tb_andor_monitor_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en, clr, m1, m2, ev_ready;
  logic        ev_valid, overflow;
  logic [17:0] ev_data;
  logic [3:0]  ev_count;

  logic        en_b, m1_b, m2_b, ev_ready_b;
  logic        ev_valid_b, overflow_b;
  logic [5:0]  ev_data_b;
  logic [3:0]  ev_count_b;

`ifdef MONCAP_DROP_CNT_EN
  logic [7:0] drop_cnt, drop_cnt_b;
`endif

  andor_monitor_capture #(.DEPTH(8), .TS_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .monitor_m1 (m1),
    .monitor_m2 (m2),
    .en         (en),
    .clr        (clr),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_data    (ev_data),
    .ev_count   (ev_count),
    .overflow   (overflow)
`ifdef MONCAP_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  andor_monitor_capture #(.DEPTH(8), .TS_W(4)) u_dut_ts4 (
    .clk        (clk),
    .rst        (rst),
    .monitor_m1 (m1_b),
    .monitor_m2 (m2_b),
    .en         (en_b),
    .clr        (1'b0),
    .ev_valid   (ev_valid_b),
    .ev_ready   (ev_ready_b),
    .ev_data    (ev_data_b),
    .ev_count   (ev_count_b),
    .overflow   (overflow_b)
`ifdef MONCAP_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt_b)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [17:0] exp_ev;

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; m1 = 1'b0; m2 = 1'b0; ev_ready = 1'b0;
    en_b = 1'b0; m1_b = 1'b0; m2_b = 1'b0; ev_ready_b = 1'b0;

    // Reset for two cycles.
    step(); step();
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_count", 32'(ev_count), 32'd0);
    check("rst_ovf",   32'(overflow), 32'd0);
    check("rst_data",  32'(ev_data),  32'd0);

    // Idle with constant 00 inputs: no events.
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_valid", 32'(ev_valid), 32'd0);
      check("idle_count", 32'(ev_count), 32'd0);
      check("idle_ovf",   32'(overflow), 32'd0);
    end

    // Re-reset so ts restarts at 0, then advance ts to 5.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step();

    // Single change at ts=5.
    m1 = 1'b1;
    step();
    check("single_valid", 32'(ev_valid), 32'd1);
    check("single_data",  32'(ev_data),  32'({16'd5, 2'b01}));
    check("single_count", 32'(ev_count), 32'd1);
    ev_ready = 1'b1;
    step();
    check("single_pop_valid", 32'(ev_valid), 32'd0);
    check("single_pop_count", 32'(ev_count), 32'd0);
    ev_ready = 1'b0;

    // Fill: toggle m1 for 10 cycles starting at ts=7; last two dropped.
    for (int k = 0; k < 10; k++) begin
      m1 = k[0];
      step();
    end
    check("fill_count", 32'(ev_count), 32'd8);
    check("fill_ovf",   32'(overflow), 32'd1);
    check("fill_head",  32'(ev_data),  32'({16'd7, 2'b00}));
`ifdef MONCAP_DROP_CNT_EN
    check("fill_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

    // Full with simultaneous push ({17,00}) and pop ({7,00}).
    ev_ready = 1'b1;
    m1 = 1'b0;
    step();
    check("fullpp_count", 32'(ev_count), 32'd8);
    check("fullpp_ovf",   32'(overflow), 32'd1);
    check("fullpp_head",  32'(ev_data),  32'({16'd8, 2'b01}));
`ifdef MONCAP_DROP_CNT_EN
    check("fullpp_drop_cnt", 32'(drop_cnt), 32'd2);
`endif

    // Drain in order: ts 8..14 then the late event at ts 17.
    for (int i = 0; i < 8; i++) begin
      if (i < 7) exp_ev = {16'(8 + i), 1'b0, 1'((i + 1) % 2)};
      else       exp_ev = {16'd17, 2'b00};
      check("drain_valid", 32'(ev_valid), 32'd1);
      check("drain_data",  32'(ev_data),  32'(exp_ev));
      step();
    end
    check("drained_valid", 32'(ev_valid), 32'd0);
    check("drained_count", 32'(ev_count), 32'd0);

    // Pop on empty: no underflow.
    step();
    check("empty_pop_count", 32'(ev_count), 32'd0);
    check("empty_pop_valid", 32'(ev_valid), 32'd0);
    ev_ready = 1'b0;

    // en=0 while toggling: no events, ts frozen at 27.
    en = 1'b0;
    {m2, m1} = 2'b01; step();
    {m2, m1} = 2'b11; step();
    {m2, m1} = 2'b10; step();
    {m2, m1} = 2'b11; step();
    check("en0_count", 32'(ev_count), 32'd0);

    // Enable with stable inputs: no spurious event.
    en = 1'b1;
    step();
    check("en1_stable_count", 32'(ev_count), 32'd0);

    {m2, m1} = 2'b10; step();
    check("en1_head", 32'(ev_data), 32'({16'd28, 2'b10}));
    {m2, m1} = 2'b11; step();
    {m2, m1} = 2'b01; step();
    check("pre_clr_count", 32'(ev_count), 32'd3);
    check("pre_clr_ovf",   32'(overflow), 32'd1);

    // Soft clear with a concurrent change (discarded); prev still updates.
    clr = 1'b1;
    {m2, m1} = 2'b00;
    step();
    check("clr_count", 32'(ev_count), 32'd0);
    check("clr_valid", 32'(ev_valid), 32'd0);
    check("clr_ovf",   32'(overflow), 32'd0);
`ifdef MONCAP_DROP_CNT_EN
    check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
    clr = 1'b0;
    {m2, m1} = 2'b01;
    step();
    check("post_clr_valid", 32'(ev_valid), 32'd1);
    check("post_clr_data",  32'(ev_data),  32'({16'd0, 2'b01}));
    check("post_clr_count", 32'(ev_count), 32'd1);

    // Reset mid-stream discards stored events.
    rst = 1'b1;
    step();
    check("midrst_valid", 32'(ev_valid), 32'd0);
    check("midrst_count", 32'(ev_count), 32'd0);
    check("midrst_data",  32'(ev_data),  32'd0);
    rst = 1'b0;

    // Timestamp wrap on the 4-bit instance: events at ts 15 then 0.
    en_b = 1'b1;
    for (int i = 0; i < 15; i++) step();
    m1_b = 1'b1; step();
    m1_b = 1'b0; step();
    check("wrap_count", 32'(ev_count_b), 32'd2);
    check("wrap_head0", 32'(ev_data_b),  32'({4'd15, 2'b01}));
    ev_ready_b = 1'b1;
    step();
    ev_ready_b = 1'b0;
    check("wrap_valid1", 32'(ev_valid_b), 32'd1);
    check("wrap_head1",  32'(ev_data_b),  32'({4'd0, 2'b00}));
    check("wrap_count1", 32'(ev_count_b), 32'd1);
    check("wrap_ovf",    32'(overflow_b), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
